lcd_bus_ctrl: RTL and testbench
===============================

Name: lcd_bus_ctrl

Overview:
Avalon-MM slave that replaces software bit-banging of the LCD 8080-style parallel write bus, which today uses separate single-bit PIOs for WE, RS, CS plus a data PIO. The CPU pushes command and data words into an internal FIFO. A timing FSM drives cs_n/rs/wr_n/data with programmable setup, strobe and hold phases. It also owns the LCD reset line.

Parameters:
DATA_W, 16, LCD data bus width (max 16, all register fields fixed at 32-bit Avalon)
FIFO_DEPTH, 16, entries in the command/data FIFO (power of 2, 2..256)
T_SETUP_RST, 1, reset value of the setup field (phase lasts field+1 cycles)
T_WR_RST, 1, reset value of the strobe-low field
T_HOLD_RST, 1, reset value of the hold field

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
read_n  in  1  Avalon read strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational (read latency 0)
lcd_cs_n  out  1  LCD chip select, active-low
lcd_rs  out  1  LCD register select (0 = command, 1 = data)
lcd_wr_n  out  1  LCD write strobe, active-low
lcd_data  out  DATA_W  LCD data bus
lcd_rst_n  out  1  LCD hardware reset, active-low

Behaviour:
- Reset values: lcd_cs_n=1, lcd_wr_n=1, lcd_rs=0, lcd_data=0, lcd_rst_n=0 (LCD held in reset until software releases it). FIFO is empty, overflow=0, timing fields take their *_RST values, FSM is IDLE. Reset assertion mid-transaction forces all of these immediately (asynchronous); no partial strobe completes.
- Register map (a write is chipselect && !write_n):
  - addr 0 DATA: write pushes {rs=1, writedata[DATA_W-1:0]}; reads as 0.
  - addr 1 CMD: write pushes {rs=0, writedata[DATA_W-1:0]}; reads as 0.
  - addr 2 CTRL/STATUS:
    - Read: [0] lcd_rst_n, [1] busy, [2] fifo_full, [3] fifo_empty, [4] overflow, [15:8] fill level.
    - Write: [0] sets lcd_rst_n. Write-1 to [4] clears overflow. Write-1 to [5] flushes the FIFO; the in-flight transaction still completes.
  - addr 3 TIMING: [3:0] t_setup, [7:4] t_wr, [11:8] t_hold; read returns the current values.
- Push rule: accepted only if count < FIFO_DEPTH at that cycle. Otherwise the word is dropped and overflow is set (sticky). A push and a pop in the same cycle leave count unchanged. If flush and push land in the same cycle, flush wins and the pushed word is discarded.
- busy = (state != IDLE) || !fifo_empty.
- FSM states IDLE, SETUP, STROBE, HOLD. A 4-bit phase counter is loaded with a field value on phase entry; the phase ends when counter==0, otherwise it decrements. Each phase therefore lasts field+1 cycles.
  - IDLE: if FIFO is non-empty, pop and register rs/data, drive cs_n=0, load t_setup, go to SETUP.
  - SETUP: wr_n=1; at end, load t_wr and go to STROBE.
  - STROBE: wr_n=0; at end, load t_hold and go to HOLD.
  - HOLD: wr_n=1, data/rs held.
    - At end with FIFO non-empty: pop the next word, keep cs_n=0 (back-to-back burst), load t_setup, go to SETUP.
    - At end with FIFO empty: cs_n=1 and go to IDLE.
- All lcd_* outputs are registered. wr_n==0 exactly while state==STROBE. Data and rs change only on entry to SETUP.
- Latency: a write accepted at edge N yields cs_n=0 at N+2, wr_n low from N+2+t_setup+1 for t_wr+1 cycles.
- A TIMING write takes effect at the next counter load; the current phase is unaffected.
- Writes to lcd_rst_n are independent of the FSM and do not stall or flush it.

Decomposition:
- Package lcd_bus_pkg holds: register address constants (ADDR_DATA=0, ADDR_CMD=1, ADDR_CTRL=2, ADDR_TIMING=3), CTRL/STATUS bit positions, the FSM state enum, and the timing field width (4).
- One sub-module, lcd_cmd_fifo: a synchronous FIFO of width DATA_W+1, with push/pop/flush, full/empty and count outputs, depth FIFO_DEPTH.

Test Plan:
- Reset, then read CTRL -> 0x0000_0008 (empty=1, rst_n=0); lcd_cs_n=1, lcd_wr_n=1.
- CTRL write 0x1, CMD write 0x0022 at edge N, default timing -> cs_n=0 and rs=0, data=0x0022 at N+2; wr_n low for cycles N+4..N+5; cs_n=1 at N+8.
- DATA writes 0xF800, 0x07E0, 0x001F in consecutive cycles -> three wr_n pulses with rs=1, cs_n held low throughout, 6 cycles between pulse starts.
- TIMING write 0x0320, then one DATA write -> setup 1 cycle, wr_n low 3 cycles, hold 4 cycles.
- 20 DATA writes in consecutive cycles at FIFO_DEPTH=16 with a slow strobe (TIMING 0xFFF) -> overflow=1, drops counted; CTRL write 0x10 clears overflow; exactly the accepted words appear on the bus, in order.
- Assert reset_n during STROBE -> wr_n and cs_n go high immediately (asynchronously); after release, FIFO is empty and no further pulses occur.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared constants and types for the LCD 8080-style bus controller.
package lcd_bus_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TIMING = 2'd3;

  localparam int CTRL_RST_BIT   = 0;
  localparam int CTRL_BUSY_BIT  = 1;
  localparam int CTRL_FULL_BIT  = 2;
  localparam int CTRL_EMPTY_BIT = 3;
  localparam int CTRL_OVF_BIT   = 4;
  localparam int CTRL_FLUSH_BIT = 5;
  localparam int CTRL_FILL_LSB  = 8;
  localparam int CTRL_FILL_W    = 8;

  localparam int TIMING_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } lcdState_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO holding {rs, data} words for the LCD bus.
// Flush beats push; a full FIFO refuses pushes even while popping.
module lcd_cmd_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             pushOk, popOk;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign pushOk    = push_i && !full_o && !flush_i;
  assign popOk     = pop_i && !empty_o && !flush_i;
  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (popOk)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (pushOk && !popOk)      count_q <= count_q + CNT_W'(1);
      else if (popOk && !pushOk) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/lcd_bus_ctrl.sv
// Avalon-MM slave that queues LCD command/data words and replays them on an
// 8080-style write bus with programmable setup/strobe/hold phases.
module lcd_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int T_SETUP_RST = 1,
  parameter int T_WR_RST    = 1,
  parameter int T_HOLD_RST  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic [DATA_W-1:0] lcd_data,
  output logic              lcd_rst_n
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = DATA_W + 1;

  lcdState_e           state_q, state_d;
  logic [TIMING_W-1:0] phaseCnt_q, phaseCnt_d;
  logic [TIMING_W-1:0] tSetup_q, tWr_q, tHold_q;
  logic                csN_q, csN_d, wrN_q, wrN_d, rs_q, rs_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rstN_q, ovf_q;

  logic              wrEn, ctrlWr, pushReq, flush, pop, fifoAvail, phaseEnd, busy;
  logic              fifoFull, fifoEmpty;
  logic [WORD_W-1:0] pushWord, popWord;
  logic [CNT_W-1:0]  fifoCount;
  logic [7:0]        fillLevel;
  logic              unusedWdata;

  assign wrEn        = chipselect && !write_n;
  assign ctrlWr      = wrEn && (address == ADDR_CTRL);
  assign pushReq     = wrEn && ((address == ADDR_DATA) || (address == ADDR_CMD));
  assign pushWord    = {address == ADDR_DATA, writedata[DATA_W-1:0]};
  assign flush       = ctrlWr && writedata[CTRL_FLUSH_BIT];
  assign fifoAvail   = !fifoEmpty && !flush;
  assign phaseEnd    = (phaseCnt_q == '0);
  assign busy        = (state_q != IDLE) || !fifoEmpty;
  assign fillLevel   = 8'(fifoCount);
  assign unusedWdata = ^writedata;

  lcd_cmd_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (pushReq),
    .pushData_i (pushWord),
    .pop_i      (pop),
    .flush_i    (flush),
    .popData_o  (popWord),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstN_q   <= 1'b0;
      ovf_q    <= 1'b0;
      tSetup_q <= TIMING_W'(T_SETUP_RST);
      tWr_q    <= TIMING_W'(T_WR_RST);
      tHold_q  <= TIMING_W'(T_HOLD_RST);
    end else begin
      if (pushReq && fifoFull) begin
        ovf_q <= 1'b1;
      end
      if (ctrlWr) begin
        rstN_q <= writedata[CTRL_RST_BIT];
        if (writedata[CTRL_OVF_BIT]) ovf_q <= 1'b0;
      end
      if (wrEn && (address == ADDR_TIMING)) begin
        tSetup_q <= writedata[3:0];
        tWr_q    <= writedata[7:4];
        tHold_q  <= writedata[11:8];
      end
    end
  end

  // Outputs are computed alongside the next state so every lcd_* pin is a flop.
  always_comb begin
    state_d    = state_q;
    phaseCnt_d = phaseCnt_q;
    csN_d      = csN_q;
    wrN_d      = wrN_q;
    rs_d       = rs_q;
    data_d     = data_q;
    pop        = 1'b0;
    if (!phaseEnd) phaseCnt_d = phaseCnt_q - TIMING_W'(1);
    case (state_q)
      IDLE: begin
        if (fifoAvail) begin
          pop            = 1'b1;
          {rs_d, data_d} = popWord;
          csN_d          = 1'b0;
          phaseCnt_d     = tSetup_q;
          state_d        = SETUP;
        end
      end
      SETUP: begin
        if (phaseEnd) begin
          phaseCnt_d = tWr_q;
          wrN_d      = 1'b0;
          state_d    = STROBE;
        end
      end
      STROBE: begin
        if (phaseEnd) begin
          phaseCnt_d = tHold_q;
          wrN_d      = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (phaseEnd) begin
          if (fifoAvail) begin
            pop            = 1'b1;
            {rs_d, data_d} = popWord;
            phaseCnt_d     = tSetup_q;
            state_d        = SETUP;
          end else begin
            csN_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      phaseCnt_q <= '0;
      csN_q      <= 1'b1;
      wrN_q      <= 1'b1;
      rs_q       <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      phaseCnt_q <= phaseCnt_d;
      csN_q      <= csN_d;
      wrN_q      <= wrN_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && !read_n) begin
      case (address)
        ADDR_CTRL: begin
          readdata[CTRL_RST_BIT]                  = rstN_q;
          readdata[CTRL_BUSY_BIT]                 = busy;
          readdata[CTRL_FULL_BIT]                 = fifoFull;
          readdata[CTRL_EMPTY_BIT]                = fifoEmpty;
          readdata[CTRL_OVF_BIT]                  = ovf_q;
          readdata[CTRL_FILL_LSB +: CTRL_FILL_W]  = fillLevel;
        end
        ADDR_TIMING: readdata[3*TIMING_W-1:0] = {tHold_q, tWr_q, tSetup_q};
        default: readdata = '0;
      endcase
    end
  end

  assign lcd_cs_n  = csN_q;
  assign lcd_wr_n  = wrN_q;
  assign lcd_rs    = rs_q;
  assign lcd_data  = data_q;
  assign lcd_rst_n = rstN_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl: bus timing, bursts, overflow and async reset,
// with a negedge monitor feeding an in-order scoreboard of expected bus words.
module tb_lcd_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rst_n;
  logic [15:0] lcd_data;

  always #5 clk = ~clk;

  lcd_bus_ctrl #(
    .DATA_W(16), .FIFO_DEPTH(16), .T_SETUP_RST(1), .T_WR_RST(1), .T_HOLD_RST(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_data(lcd_data),
    .lcd_rst_n(lcd_rst_n)
  );

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int pulseCnt = 0;
  int csRiseCnt = 0;
  int lastWrFall = 0, lastWrRise = 0, lastCsFall = 0, lastCsRise = 0, lastWidth = 0;
  int starts[$];
  logic [16:0] expQ[$];
  logic prevWr = 1'b1;
  logic prevCs = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Bus monitor: every strobe start is matched against the next expected word.
  always @(negedge clk) begin
    cycleCnt = cycleCnt + 1;
    if (prevWr && !lcd_wr_n) begin
      pulseCnt++;
      lastWrFall = cycleCnt;
      starts.push_back(cycleCnt);
      checkOutput("cs low at strobe", 32'(lcd_cs_n), 32'd0);
      if (expQ.size() == 0)
        checkOutput("unexpected word", {15'b0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
      else
        checkOutput("bus word", {15'b0, lcd_rs, lcd_data}, {15'b0, expQ.pop_front()});
    end
    if (!prevWr && lcd_wr_n) begin
      lastWrRise = cycleCnt;
      lastWidth  = cycleCnt - lastWrFall;
    end
    if (prevCs && !lcd_cs_n) lastCsFall = cycleCnt;
    if (!prevCs && lcd_cs_n) begin
      lastCsRise = cycleCnt;
      csRiseCnt++;
    end
    prevWr = lcd_wr_n;
    prevCs = lcd_cs_n;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic waitDrain(input int budget);
    logic [31:0] st;
    int n = 0;
    readReg(2'd2, st);
    while (st[1] && n < budget) begin
      tick(1);
      readReg(2'd2, st);
      n++;
    end
    checkOutput("drain busy", 32'(st[1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int k, base, riseBase, snap, n;

    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 2'd0; writedata = '0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    tick(1);

    // Reset state
    readReg(2'd2, rd);
    checkOutput("reset status", rd, 32'h0000_0008);
    checkOutput("reset cs_n", 32'(lcd_cs_n), 32'd1);
    checkOutput("reset wr_n", 32'(lcd_wr_n), 32'd1);
    checkOutput("reset rst_n", 32'(lcd_rst_n), 32'd0);
    checkOutput("reset data", 32'(lcd_data), 32'd0);
    checkOutput("reset rs", 32'(lcd_rs), 32'd0);
    readReg(2'd3, rd);
    checkOutput("reset timing", rd, 32'h0000_0111);

    // Single command with default timing
    applyStimulus(2'd2, 32'h1);
    checkOutput("rst_n released", 32'(lcd_rst_n), 32'd1);
    expQ.push_back({1'b0, 16'h0022});
    k = cycleCnt;
    applyStimulus(2'd1, 32'h0000_0022);
    tick(1);
    checkOutput("cmd cs_n low", 32'(lcd_cs_n), 32'd0);
    checkOutput("cmd rs", 32'(lcd_rs), 32'd0);
    checkOutput("cmd data", 32'(lcd_data), 32'h22);
    waitDrain(100);
    checkOutput("cmd cs fall cycle", 32'(lastCsFall - k), 32'd2);
    checkOutput("cmd wr fall cycle", 32'(lastWrFall - k), 32'd4);
    checkOutput("cmd wr width", 32'(lastWidth), 32'd2);
    checkOutput("cmd cs rise cycle", 32'(lastCsRise - k), 32'd8);

    // Three back-to-back data words
    base = starts.size();
    riseBase = csRiseCnt;
    expQ.push_back({1'b1, 16'hF800});
    expQ.push_back({1'b1, 16'h07E0});
    expQ.push_back({1'b1, 16'h001F});
    k = cycleCnt;
    applyStimulus(2'd0, 32'hF800);
    applyStimulus(2'd0, 32'h07E0);
    applyStimulus(2'd0, 32'h001F);
    waitDrain(200);
    checkOutput("burst pulses", 32'(starts.size() - base), 32'd3);
    if (starts.size() >= base + 3) begin
      checkOutput("burst first start", 32'(starts[base] - k), 32'd4);
      checkOutput("burst spacing 1", 32'(starts[base+1] - starts[base]), 32'd6);
      checkOutput("burst spacing 2", 32'(starts[base+2] - starts[base+1]), 32'd6);
    end
    checkOutput("burst cs rises", 32'(csRiseCnt - riseBase), 32'd1);
    checkOutput("burst wr width", 32'(lastWidth), 32'd2);

    // Custom timing: setup 1, strobe 3, hold 4
    applyStimulus(2'd3, 32'h0000_0320);
    readReg(2'd3, rd);
    checkOutput("timing readback", rd, 32'h0000_0320);
    expQ.push_back({1'b1, 16'hABCD});
    k = cycleCnt;
    applyStimulus(2'd0, 32'hABCD);
    waitDrain(100);
    checkOutput("t cs fall cycle", 32'(lastCsFall - k), 32'd2);
    checkOutput("t setup length", 32'(lastWrFall - lastCsFall), 32'd1);
    checkOutput("t strobe length", 32'(lastWidth), 32'd3);
    checkOutput("t hold length", 32'(lastCsRise - lastWrRise), 32'd4);

    // Overflow: 20 writes into a 16-deep FIFO with a slow strobe
    applyStimulus(2'd3, 32'h0000_0FFF);
    base = pulseCnt;
    for (int i = 0; i < 20; i++) begin
      if (i <= 16) expQ.push_back({1'b1, 16'(16'h1000 + i)});
      applyStimulus(2'd0, 32'(32'h1000 + i));
    end
    readReg(2'd2, rd);
    checkOutput("overflow status", rd, 32'h0000_1017);
    applyStimulus(2'd2, 32'h10);
    readReg(2'd2, rd);
    checkOutput("overflow cleared", rd, 32'h0000_1006);
    applyStimulus(2'd2, 32'h1);
    applyStimulus(2'd3, 32'h0000_0111);
    waitDrain(3000);
    checkOutput("accepted words", 32'(pulseCnt - base), 32'd17);
    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
    readReg(2'd2, rd);
    checkOutput("post drain status", rd, 32'h0000_0009);

    // Asynchronous reset in the middle of a strobe
    applyStimulus(2'd3, 32'h0000_00F0);
    expQ.push_back({1'b1, 16'h5555});
    applyStimulus(2'd0, 32'h5555);
    applyStimulus(2'd0, 32'hAAAA);
    n = 0;
    while (lcd_wr_n && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("strobe reached", 32'(lcd_wr_n), 32'd0);
    tick(3);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async wr_n", 32'(lcd_wr_n), 32'd1);
    checkOutput("async cs_n", 32'(lcd_cs_n), 32'd1);
    checkOutput("async data", 32'(lcd_data), 32'd0);
    checkOutput("async rst_n", 32'(lcd_rst_n), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    snap = pulseCnt;
    readReg(2'd2, rd);
    checkOutput("post reset status", rd, 32'h0000_0008);
    readReg(2'd3, rd);
    checkOutput("post reset timing", rd, 32'h0000_0111);
    tick(40);
    checkOutput("no pulses after reset", 32'(pulseCnt), 32'(snap));
    checkOutput("final scoreboard", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
